ibuf_load_packer: RTL and testbench
===================================

Name: ibuf_load_packer

Overview:
- Upstream fill stage for the input buffer.
- Accepts a command (base address, word count) and a narrow valid/ready data stream from the DMA read path.
- Packs consecutive narrow beats into full-width buffer words and issues one write per packed word on the buffer's mem_write_req/addr/data interface.
- The buffer write port has no backpressure, so this block owns all flow control toward the DMA side.

Parameters:
- S_DATA_WIDTH, 64, width of one incoming stream beat.
- MEM_DATA_WIDTH, 256, width of one buffer write word; must be an integer multiple of S_DATA_WIDTH.
- MEM_ADDR_WIDTH, 14, buffer write address width.
- NUM_WORDS_W, 16, width of the word-count field.
- BEATS_PER_WORD, MEM_DATA_WIDTH/S_DATA_WIDTH, derived; 4 at defaults.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle load command strobe
- cfg_base_addr  in  MEM_ADDR_WIDTH  first buffer word address
- cfg_num_words  in  NUM_WORDS_W  number of full buffer words to write
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat accept
- s_data  in  S_DATA_WIDTH  stream beat payload
- mem_write_req  out  1  buffer write strobe
- mem_write_addr  out  MEM_ADDR_WIDTH  buffer write address
- mem_write_data  out  MEM_DATA_WIDTH  packed buffer word

Behaviour:
- Reset (reset low, asynchronous): state IDLE; busy, done, s_ready and mem_write_req are 0; mem_write_addr and mem_write_data are 0. All counters and the pack register clear, and any partial word is discarded. A reset asserted mid-load aborts the load with no done pulse.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - s_ready=0.
  - cfg_start=1 latches base address and word count and clears the beat and word counters.
  - If cfg_num_words==0, go to DONE; otherwise go to LOAD.
- LOAD:
  - s_ready=1, decoded from state only; no dependence on s_valid.
  - A beat is accepted when s_valid && s_ready. Beat k of a word (k=0 first) is written to pack bits [k*S_DATA_WIDTH +: S_DATA_WIDTH]. Beat 0 lands in the LSBs.
  - The beat counter wraps at BEATS_PER_WORD-1.
  - On acceptance of beat BEATS_PER_WORD-1, the next cycle has mem_write_req=1 for exactly one cycle, with mem_write_addr = base + word_index (modulo 2^MEM_ADDR_WIDTH) and mem_write_data = the completed word.
  - word_index then increments.
  - If that beat completes word cfg_num_words-1, go to DONE. s_ready is therefore 0 from the cycle after the final beat.
- DONE: lasts one cycle. done=1, and it coincides with the final mem_write_req. Then go to IDLE.
- busy=1 in LOAD and DONE; busy=0 in IDLE.
- Latency: final beat accepted in cycle T → final write and done in cycle T+1 → busy=0 in T+2.
- cfg_start while busy is ignored, and the latched parameters are unchanged.
- A stalled stream (s_valid=0) holds all counters and the partial pack register indefinitely. There is no timeout.
- Address wrap: base + index overflowing MEM_ADDR_WIDTH wraps silently to 0.
- mem_write_addr and mem_write_data hold their last value when mem_write_req=0.
- Every write is back-to-back capable: one write at most every BEATS_PER_WORD cycles at full stream rate.

Test Plan:
- Reset sanity: hold reset low 5 cycles while driving s_valid=1 and cfg_start=1 → all outputs 0, s_ready=0, no writes.
- Single word: base=0x010, num=1, four beats 0x11..,0x22..,0x33..,0x44.. back-to-back → one write at addr 0x010, data={beat3,beat2,beat1,beat0}, done in the same cycle, busy low the cycle after.
- Throttled multi-word: base=0x100, num=3, s_valid random ~50% → exactly 3 writes to 0x100, 0x101, 0x102 with correct packing, s_ready=0 after the 12th beat, one done pulse.
- Address wrap: base=0x3FFF, num=2 → writes to 0x3FFF then 0x0000.
- Zero count plus ignored start: num=0 → done one cycle after start with no writes and s_ready never high. A second cfg_start issued mid-LOAD → no change in address sequence or count.
- Reset mid-op: start num=4, pull reset low after 6 beats → outputs clear immediately with no done. A fresh load of num=1 afterwards packs from beat 0 correctly.

Source files
------------

// File: rtl/ibuf_load_packer.sv
// Input-buffer fill stage: packs narrow DMA stream beats into full-width
// buffer words and issues one buffer write per completed word.
module ibuf_load_packer #(
  parameter int unsigned S_DATA_WIDTH   = 64,
  parameter int unsigned MEM_DATA_WIDTH = 256,
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter int unsigned NUM_WORDS_W    = 16,
  parameter int unsigned BEATS_PER_WORD = MEM_DATA_WIDTH / S_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [NUM_WORDS_W-1:0]    cfg_num_words,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [S_DATA_WIDTH-1:0]   s_data,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data
);

  localparam int unsigned BEAT_W = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_next;

  logic [MEM_ADDR_WIDTH-1:0] base_addr;
  logic [NUM_WORDS_W-1:0]    num_words;
  logic [NUM_WORDS_W-1:0]    word_idx;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [MEM_DATA_WIDTH-1:0] pack;
  logic [MEM_DATA_WIDTH-1:0] pack_next;
  logic                      accept;
  logic                      last_beat;
  logic                      last_word;
  logic                      start_load;

  // Acceptance is built from state directly so s_ready never loops back into it.
  assign accept     = s_valid && (state == LOAD);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_word  = (word_idx == (num_words - NUM_WORDS_W'(1)));
  assign start_load = cfg_start && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next = (cfg_num_words == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept && last_beat && last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The completing beat is merged combinationally so the write carries the full word.
  always_comb begin
    pack_next = pack;
    pack_next[beat_cnt*S_DATA_WIDTH +: S_DATA_WIDTH] = s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_addr      <= '0;
      num_words      <= '0;
      word_idx       <= '0;
      beat_cnt       <= '0;
      pack           <= '0;
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      mem_write_req <= 1'b0;
      if (start_load) begin
        base_addr <= cfg_base_addr;
        num_words <= cfg_num_words;
        word_idx  <= '0;
        beat_cnt  <= '0;
        pack      <= '0;
      end else if (accept) begin
        pack <= pack_next;
        if (last_beat) begin
          beat_cnt       <= '0;
          word_idx       <= word_idx + 1'b1;
          mem_write_req  <= 1'b1;
          mem_write_addr <= base_addr + MEM_ADDR_WIDTH'(word_idx);
          mem_write_data <= pack_next;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibuf_load_packer.sv
// Directed self-checking bench for ibuf_load_packer at default parameters.
module tb_ibuf_load_packer;

  logic         clk;
  logic         reset;
  logic         cfg_start;
  logic [13:0]  cfg_base_addr;
  logic [15:0]  cfg_num_words;
  logic         busy;
  logic         done;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic         mem_write_req;
  logic [13:0]  mem_write_addr;
  logic [255:0] mem_write_data;

  int checks = 0;
  int errors = 0;

  logic [63:0]  tx_q[$];
  logic [13:0]  wr_addr_q[$];
  logic [255:0] wr_data_q[$];
  int           done_cnt = 0;

  ibuf_load_packer #(
    .S_DATA_WIDTH   (64),
    .MEM_DATA_WIDTH (256),
    .MEM_ADDR_WIDTH (14),
    .NUM_WORDS_W    (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_words  (cfg_num_words),
    .busy           (busy),
    .done           (done),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .mem_write_req  (mem_write_req),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done recorder, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (mem_write_req) begin
      wr_addr_q.push_back(mem_write_addr);
      wr_data_q.push_back(mem_write_data);
    end
    if (done) done_cnt++;
  end

  function automatic logic [63:0] pat(input int unsigned seed, input int unsigned w,
                                      input int unsigned b);
    logic [7:0] x;
    x = 8'(seed * 32 + w * 4 + b + 1);
    return {x, 8'hC3, x, 8'h3C, x, 8'hA5, x, 8'h5A};
  endfunction

  function automatic logic [255:0] exp_word(input int unsigned seed, input int unsigned w);
    logic [255:0] r;
    r = '0;
    for (int unsigned b = 0; b < 4; b++) r[b*64 +: 64] = pat(seed, w, b);
    return r;
  endfunction

  task automatic push_beats(input int unsigned seed, input int unsigned first,
                            input int unsigned count);
    for (int unsigned g = first; g < first + count; g++) tx_q.push_back(pat(seed, g / 4, g % 4));
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_cmd(input logic [13:0] base, input logic [15:0] num);
    @(negedge clk);
    cfg_base_addr = base;
    cfg_num_words = num;
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Drives tx_q onto the stream; returns at the negedge of the last accepted beat.
  task automatic run_stream(input bit throttle, output bit timed_out);
    int unsigned cyc;
    cyc = 0;
    timed_out = 1'b0;
    while (tx_q.size() > 0 && !timed_out) begin
      @(negedge clk);
      if (cyc >= 2000) begin
        timed_out = 1'b1;
        s_valid   = 1'b0;
      end else begin
        cyc++;
        s_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = tx_q[0];
        if (s_valid && s_ready) void'(tx_q.pop_front());
      end
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    cfg_start     = 1'b1;
    cfg_base_addr = 14'h0AA;
    cfg_num_words = 16'd1;
    s_valid       = 1'b1;
    s_data        = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, s_ready, mem_write_req} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d: got %b expected 0000", i, {busy, done, s_ready, mem_write_req});
      end
      checks++;
      if (mem_write_addr !== 14'h0 || mem_write_data !== 256'h0) begin
        errors++;
        $display("FAIL reset_bus cycle %0d: got addr %h data %h expected 0", i, mem_write_addr, mem_write_data);
      end
    end
    cfg_start = 1'b0;
    s_valid   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (wr_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_writes: got %0d expected 0", wr_addr_q.size());
    end
    clear_log();
  endtask

  task automatic test_single_word();
    bit to;
    clear_log();
    start_cmd(14'h010, 16'd1);
    tx_q.push_back(64'h1111_1111_1111_1111);
    tx_q.push_back(64'h2222_2222_2222_2222);
    tx_q.push_back(64'h3333_3333_3333_3333);
    tx_q.push_back(64'h4444_4444_4444_4444);
    run_stream(1'b0, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", to); end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if ({mem_write_req, done, busy, s_ready} !== 4'b1110) begin
      errors++;
      $display("FAIL single_write_cycle: got req/done/busy/ready %b expected 1110",
               {mem_write_req, done, busy, s_ready});
    end
    checks++;
    if (mem_write_addr !== 14'h010) begin
      errors++; $display("FAIL single_addr: got %h expected 010", mem_write_addr);
    end
    checks++;
    if (mem_write_data !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++; $display("FAIL single_data: got %h", mem_write_data);
    end
    @(negedge clk);
    checks++;
    if ({mem_write_req, done, busy} !== 3'b000) begin
      errors++; $display("FAIL single_after: got req/done/busy %b expected 000", {mem_write_req, done, busy});
    end
    checks++;
    if (mem_write_addr !== 14'h010) begin
      errors++; $display("FAIL single_addr_hold: got %h expected 010", mem_write_addr);
    end
    checks++;
    if (wr_addr_q.size() !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL single_counts: got writes %0d dones %0d expected 1 1", wr_addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_throttled();
    bit to;
    clear_log();
    start_cmd(14'h100, 16'd3);
    push_beats(1, 0, 12);
    run_stream(1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL thr_timeout: got %b expected 0", to); end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if ({s_ready, done} !== 2'b01) begin
      errors++; $display("FAIL thr_final: got ready/done %b expected 01", {s_ready, done});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 3 || done_cnt !== 1) begin
      errors++; $display("FAIL thr_counts: got writes %0d dones %0d expected 3 1", wr_addr_q.size(), done_cnt);
    end else begin
      for (int unsigned w = 0; w < 3; w++) begin
        checks++;
        if (wr_addr_q[w] !== 14'(14'h100 + w) || wr_data_q[w] !== exp_word(1, w)) begin
          errors++;
          $display("FAIL thr_word%0d: got addr %h data %h expected addr %h data %h",
                   w, wr_addr_q[w], wr_data_q[w], 14'(14'h100 + w), exp_word(1, w));
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit to;
    clear_log();
    start_cmd(14'h3FFF, 16'd2);
    push_beats(3, 0, 8);
    run_stream(1'b0, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL wrap_timeout: got %b expected 0", to); end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL wrap_count: got %0d expected 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 14'h3FFF || wr_addr_q[1] !== 14'h0000) begin
        errors++; $display("FAIL wrap_addr: got %h %h expected 3fff 0000", wr_addr_q[0], wr_addr_q[1]);
      end
      checks++;
      if (wr_data_q[1] !== exp_word(3, 1)) begin
        errors++; $display("FAIL wrap_data: got %h expected %h", wr_data_q[1], exp_word(3, 1));
      end
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    s_valid = 1'b1;
    s_data  = 64'hFFFF_0000_FFFF_0000;
    start_cmd(14'h123, 16'd0);
    checks++;
    if ({done, busy, s_ready} !== 3'b110) begin
      errors++; $display("FAIL zero_done: got done/busy/ready %b expected 110", {done, busy, s_ready});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, s_ready} !== 3'b000) begin
      errors++; $display("FAIL zero_idle: got done/busy/ready %b expected 000", {done, busy, s_ready});
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL zero_counts: got writes %0d dones %0d expected 0 1", wr_addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_ignored_start();
    bit to;
    clear_log();
    start_cmd(14'h200, 16'd2);
    push_beats(4, 0, 5);
    run_stream(1'b0, to);
    @(negedge clk);
    s_valid       = 1'b0;
    cfg_base_addr = 14'h050;
    cfg_num_words = 16'd1;
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    push_beats(4, 5, 3);
    run_stream(1'b0, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL ign_timeout: got %b expected 0", to); end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 2 || done_cnt !== 1) begin
      errors++; $display("FAIL ign_counts: got writes %0d dones %0d expected 2 1", wr_addr_q.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr_q[0] !== 14'h200 || wr_addr_q[1] !== 14'h201) begin
        errors++; $display("FAIL ign_addr: got %h %h expected 200 201", wr_addr_q[0], wr_addr_q[1]);
      end
      checks++;
      if (wr_data_q[0] !== exp_word(4, 0) || wr_data_q[1] !== exp_word(4, 1)) begin
        errors++; $display("FAIL ign_data: got %h / %h", wr_data_q[0], wr_data_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit to;
    clear_log();
    start_cmd(14'h300, 16'd4);
    push_beats(5, 0, 6);
    run_stream(1'b0, to);
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    checks++;
    if ({busy, done, s_ready, mem_write_req} !== 4'b0000 || mem_write_addr !== 14'h0 ||
        mem_write_data !== 256'h0) begin
      errors++;
      $display("FAIL midrst_clear: got ctrl %b addr %h data %h expected all 0",
               {busy, done, s_ready, mem_write_req}, mem_write_addr, mem_write_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checks++;
    if (wr_addr_q.size() !== 1 || done_cnt !== 0) begin
      errors++; $display("FAIL midrst_counts: got writes %0d dones %0d expected 1 0", wr_addr_q.size(), done_cnt);
    end
    clear_log();
    start_cmd(14'h020, 16'd1);
    push_beats(6, 0, 4);
    run_stream(1'b0, to);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (mem_write_req !== 1'b1 || done !== 1'b1 || mem_write_addr !== 14'h020 ||
        mem_write_data !== exp_word(6, 0)) begin
      errors++;
      $display("FAIL midrst_reload: got req %b done %b addr %h data %h expected 1 1 020 %h",
               mem_write_req, done, mem_write_addr, mem_write_data, exp_word(6, 0));
    end
  endtask

  initial begin
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_num_words = '0;
    s_valid       = 1'b0;
    s_data        = '0;
    reset         = 1'b0;
    test_reset();
    test_single_word();
    test_throttled();
    test_addr_wrap();
    test_zero_count();
    test_ignored_start();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
